tcb_gpio_irq: RTL and testbench

- Parametrised next-generation TCB GPIO peripheral: GW-bit output/enable/input registers, plus atomic set/clear of the output register.
- Adds per-pin rising/falling-edge interrupt detection with a sticky, write-1-to-clear status register and a single level interrupt output.
- Sits as a TCB subordinate on the peripheral bus: flattened common read/write channel, 32-bit data, response delay 1.

---
 rtl/tcb_gpio_irq_if.sv | 32 +++
 rtl/tcb_gpio_irq.sv | 167 ++++++++++++++++
 tb/tb_tcb_gpio_irq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcb_gpio_irq_if.sv
// ============================================================================
//  Module      : tcb_gpio_irq_if
//  Description : TCB peripheral bus bundle (flattened request channel,
//                32-bit data, registered response one cycle after transfer).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tcb_gpio_irq_if #(
    parameter int ADW = 5
);
    logic            vld;
    logic            rdy;
    logic            wen;
    logic [ADW-1:0]  adr;
    logic [3:0]      ben;
    logic [31:0]     wdt;
    logic [31:0]     rdt;
    logic            err;

    modport master (
        output vld, wen, adr, ben, wdt,
        input  rdy, rdt, err
    );

    modport slave (
        input  vld, wen, adr, ben, wdt,
        output rdy, rdt, err
    );
endinterface

`default_nettype wire

// File: rtl/tcb_gpio_irq.sv
// ============================================================================
//  Module      : tcb_gpio_irq
//  Description : TCB GPIO peripheral with output/enable/input registers,
//                atomic set/clear of OUT, per-pin rise/fall edge detection,
//                sticky W1C status and a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcb_gpio_irq #(
    parameter int GW      = 32,
    parameter int CFG_CDC = 2,
    parameter int ADW     = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tcb_gpio_irq_if.slave       tcb,
    output logic [GW-1:0]       gpio_o,
    output logic [GW-1:0]       gpio_e,
    input  wire logic [GW-1:0]  gpio_i,
    output logic                irq
);

    // word index of each register
    localparam logic [2:0] C_A_OUT  = 3'd0;
    localparam logic [2:0] C_A_ENA  = 3'd1;
    localparam logic [2:0] C_A_IN   = 3'd2;
    localparam logic [2:0] C_A_SET  = 3'd3;
    localparam logic [2:0] C_A_CLR  = 3'd4;
    localparam logic [2:0] C_A_RISE = 3'd5;
    localparam logic [2:0] C_A_FALL = 3'd6;
    localparam logic [2:0] C_A_STS  = 3'd7;

    logic [GW-1:0] r_out;
    logic [GW-1:0] r_ena;
    logic [GW-1:0] r_rise;
    logic [GW-1:0] r_fall;
    logic [GW-1:0] r_sts;
    logic [GW-1:0] r_prev;
    logic [31:0]   r_rdt;
    logic          r_err;

    logic [GW-1:0] w_sync;
    logic [2:0]    w_idx;
    logic          w_bad;
    logic          w_wr;
    logic [31:0]   w_bm32;
    logic [GW-1:0] w_wd;
    logic [GW-1:0] w_clr;
    logic [GW-1:0] w_rise_evt;
    logic [GW-1:0] w_fall_evt;
    logic [31:0]   w_rdat;
    logic          w_unused;

    assign tcb.rdy = 1'b1;
    assign w_idx   = tcb.adr[4:2];

    // anything at or above word 8 of the local window is unmapped
    generate
        if (ADW > 5) begin : g_err_decode
            assign w_bad = |tcb.adr[ADW-1:5];
        end else begin : g_no_err_decode
            assign w_bad = 1'b0;
        end
    endgenerate

    // byte-enable mask applied to every write flavour (plain, set, clear, w1c)
    assign w_bm32 = {{8{tcb.ben[3]}}, {8{tcb.ben[2]}}, {8{tcb.ben[1]}}, {8{tcb.ben[0]}}};
    assign w_wd   = tcb.wdt[GW-1:0] & w_bm32[GW-1:0];
    assign w_wr   = tcb.vld & tcb.wen & ~w_bad;
    assign w_clr  = (w_wr && (w_idx == C_A_STS)) ? w_wd : '0;

    // address bits [1:0] and data bits above GW carry no information here
    assign w_unused = ^{tcb.adr[1:0], tcb.wdt, w_bm32};

    // input synchroniser; zero stages samples the pads directly
    generate
        if (CFG_CDC > 0) begin : g_sync
            logic [GW-1:0] r_stage [CFG_CDC];

            // shift pad values through the synchroniser chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < CFG_CDC; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= gpio_i;
                    for (int i = 1; i < CFG_CDC; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign w_sync = r_stage[CFG_CDC-1];
        end else begin : g_sync_bypass
            assign w_sync = gpio_i;
        end
    endgenerate

    assign w_rise_evt = w_sync & ~r_prev & r_rise;
    assign w_fall_evt = ~w_sync & r_prev & r_fall;

    // delayed copy of the synchronised inputs for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= '0;
        else      r_prev <= w_sync;
    end

    // control registers written from the bus, with byte-masked merge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_ena  <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else if (w_wr) begin
            case (w_idx)
                C_A_OUT:  r_out  <= (r_out  & ~w_bm32[GW-1:0]) | w_wd;
                C_A_ENA:  r_ena  <= (r_ena  & ~w_bm32[GW-1:0]) | w_wd;
                C_A_SET:  r_out  <= r_out | w_wd;
                C_A_CLR:  r_out  <= r_out & ~w_wd;
                C_A_RISE: r_rise <= (r_rise & ~w_bm32[GW-1:0]) | w_wd;
                C_A_FALL: r_fall <= (r_fall & ~w_bm32[GW-1:0]) | w_wd;
                default:  ;
            endcase
        end
    end

    // sticky status: new events override a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sts <= '0;
        else      r_sts <= (r_sts & ~w_clr) | w_rise_evt | w_fall_evt;
    end

    // read-data multiplexer; write-only and unmapped words read as zero
    always_comb begin
        w_rdat = '0;
        if (!w_bad) begin
            case (w_idx)
                C_A_OUT:  w_rdat = 32'(r_out);
                C_A_ENA:  w_rdat = 32'(r_ena);
                C_A_IN:   w_rdat = 32'(w_sync);
                C_A_RISE: w_rdat = 32'(r_rise);
                C_A_FALL: w_rdat = 32'(r_fall);
                C_A_STS:  w_rdat = 32'(r_sts);
                default:  w_rdat = '0;
            endcase
        end
    end

    // registered response, held between transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdt <= '0;
            r_err <= 1'b0;
        end else if (tcb.vld) begin
            r_rdt <= tcb.wen ? 32'd0 : w_rdat;
            r_err <= w_bad;
        end
    end

    assign tcb.rdt = r_rdt;
    assign tcb.err = r_err;
    assign gpio_o  = r_out;
    assign gpio_e  = r_ena;
    assign irq     = |r_sts;

endmodule

`default_nettype wire

// File: tb/tb_tcb_gpio_irq.sv
// ============================================================================
//  Module      : tb_tcb_gpio_irq
//  Description : Directed self-checking bench for tcb_gpio_irq
//                (GW=32, CFG_CDC=2, ADW=6).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcb_gpio_irq;

    localparam int GW      = 32;
    localparam int CFG_CDC = 2;
    localparam int ADW     = 6;

    logic          clk;
    logic          rst;
    logic [GW-1:0] gpio_o;
    logic [GW-1:0] gpio_e;
    logic [GW-1:0] gpio_i;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        bit          chk_rdt;
        logic [31:0] rdt;
        logic        err;
    } exp_t;

    exp_t sb[$];

    tcb_gpio_irq_if #(.ADW(ADW)) tcb ();

    tcb_gpio_irq #(
        .GW      (GW),
        .CFG_CDC (CFG_CDC),
        .ADW     (ADW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tcb    (tcb),
        .gpio_o (gpio_o),
        .gpio_e (gpio_e),
        .gpio_i (gpio_i),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one bus transfer: drive at a negedge, transfer at the next posedge,
    // response compared at the following negedge
    task automatic tx(input string tag, input logic wen, input logic [ADW-1:0] adr,
                      input logic [3:0] ben, input logic [31:0] wdt,
                      input logic [31:0] exp_rdt, input logic exp_err);
        exp_t e;
        exp_t got;
        tcb.vld = 1'b1;
        tcb.wen = wen;
        tcb.adr = adr;
        tcb.ben = ben;
        tcb.wdt = wdt;
        e.tag     = tag;
        e.chk_rdt = !wen || exp_err;
        e.rdt     = exp_rdt;
        e.err     = exp_err;
        sb.push_back(e);
        @(negedge clk);
        tcb.vld = 1'b0;
        tcb.wen = 1'b0;
        got = sb.pop_front();
        chk({got.tag, ".err"}, 32'(tcb.err), 32'(got.err));
        if (got.chk_rdt) chk({got.tag, ".rdt"}, tcb.rdt, got.rdt);
    endtask

    task automatic wr(input string tag, input logic [ADW-1:0] adr, input logic [31:0] wdt,
                      input logic [3:0] ben = 4'hF, input logic exp_err = 1'b0);
        tx(tag, 1'b1, adr, ben, wdt, 32'd0, exp_err);
    endtask

    task automatic rd(input string tag, input logic [ADW-1:0] adr, input logic [31:0] exp,
                      input logic exp_err = 1'b0);
        tx(tag, 1'b0, adr, 4'hF, 32'd0, exp, exp_err);
    endtask

    initial begin
        rst     = 1'b0;
        gpio_i  = '0;
        tcb.vld = 1'b0;
        tcb.wen = 1'b0;
        tcb.adr = '0;
        tcb.ben = '0;
        tcb.wdt = '0;

        // reset state
        idle(3);
        rst = 1'b1;
        idle(1);
        chk("rst.gpio_o", gpio_o, 32'd0);
        chk("rst.gpio_e", gpio_e, 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        chk("rst.rdt", tcb.rdt, 32'd0);
        chk("rst.rdy", 32'(tcb.rdy), 32'd1);
        for (int i = 0; i < 8; i++) rd($sformatf("rst.rd%0d", i), 6'(i * 4), 32'd0);

        // atomic set/clear with byte enables
        wr("out.wr", 6'h00, 32'h0123_4567);
        chk("out.gpio_o", gpio_o, 32'h0123_4567);
        wr("set.wr", 6'h0C, 32'hF000_0000);
        rd("set.rd", 6'h00, 32'hF123_4567);
        wr("clr.wr", 6'h10, 32'h0000_0067);
        rd("clr.rd", 6'h00, 32'hF123_4500);
        wr("clrb.wr", 6'h10, 32'hFFFF_FFFF, 4'b0001);
        rd("clrb.rd", 6'h00, 32'hF123_4500);
        wr("setb.wr", 6'h0C, 32'hFFFF_FFFF, 4'b0010);
        rd("setb.rd", 6'h00, 32'hF123_FF00);
        wr("ena.wr", 6'h04, 32'hFFFF_FFFF, 4'b0101);
        chk("ena.gpio_e", gpio_e, 32'h00FF_00FF);
        rd("set.rdwo", 6'h0C, 32'd0);
        wr("in.wr", 6'h08, 32'h1234_5678);
        rd("in.rd0", 6'h08, 32'd0);
        idle(1);
        chk("hold.rdt", tcb.rdt, 32'd0);

        // input synchroniser latency
        gpio_i = 32'h89AB_CDEF;
        rd("cdc.rd0", 6'h08, 32'd0);
        rd("cdc.rd1", 6'h08, 32'd0);
        rd("cdc.rd2", 6'h08, 32'h89AB_CDEF);
        idle(1);
        chk("cdc.hold", tcb.rdt, 32'h89AB_CDEF);
        rd("sts.none", 6'h1C, 32'd0);
        gpio_i = '0;
        idle(4);

        // edge interrupt sequence
        wr("rise.wr", 6'h14, 32'h0000_0001);
        wr("fall.wr", 6'h18, 32'h0000_0002);
        rd("rise.rd", 6'h14, 32'h0000_0001);
        gpio_i = 32'h3;
        idle(1);
        chk("irq.c1", 32'(irq), 32'd0);
        idle(1);
        chk("irq.c2", 32'(irq), 32'd0);
        idle(1);
        chk("irq.c3", 32'(irq), 32'd1);
        rd("sts.rise", 6'h1C, 32'h1);
        gpio_i = '0;
        idle(4);
        rd("sts.fall", 6'h1C, 32'h3);
        wr("w1c.b0", 6'h1C, 32'h1);
        rd("sts.w1c0", 6'h1C, 32'h2);
        chk("irq.w1c0", 32'(irq), 32'd1);
        wr("w1c.b1", 6'h1C, 32'h2);
        chk("irq.w1c1", 32'(irq), 32'd0);

        // status clear and new rising edge on the same edge: set wins
        gpio_i = 32'h1;
        idle(4);
        chk("sim.pre", 32'(irq), 32'd1);
        gpio_i = '0;
        idle(4);
        gpio_i = 32'h1;
        idle(2);
        wr("sim.w1c", 6'h1C, 32'h1);
        chk("sim.irq", 32'(irq), 32'd1);
        rd("sim.sts", 6'h1C, 32'h1);
        wr("sim.clr", 6'h1C, 32'h1);
        rd("sim.sts0", 6'h1C, 32'h0);

        // disabled edges are not recorded, enabling later records nothing
        wr("dis.rise", 6'h14, 32'h0);
        gpio_i = '0;
        idle(4);
        gpio_i = 32'h4;
        idle(4);
        wr("en.rise", 6'h14, 32'h4);
        idle(3);
        rd("dis.sts", 6'h1C, 32'h0);
        chk("dis.irq", 32'(irq), 32'd0);

        // unmapped window
        rd("err.rd", 6'h20, 32'd0, 1'b1);
        wr("err.wr", 6'h24, 32'hFFFF_FFFF, 4'hF, 1'b1);
        chk("err.gpio_e", gpio_e, 32'h00FF_00FF);
        rd("err.clear", 6'h04, 32'h00FF_00FF);

        // reset asserted during a write: no write, no response
        tcb.vld = 1'b1;
        tcb.wen = 1'b1;
        tcb.adr = 6'h00;
        tcb.ben = 4'hF;
        tcb.wdt = 32'hDEAD_BEEF;
        #2 rst = 1'b0;
        @(negedge clk);
        tcb.vld = 1'b0;
        tcb.wen = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        chk("mid.gpio_o", gpio_o, 32'd0);
        chk("mid.gpio_e", gpio_e, 32'd0);
        chk("mid.rdt", tcb.rdt, 32'd0);
        chk("mid.err", 32'(tcb.err), 32'd0);
        rd("mid.rd", 6'h00, 32'd0);

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
